// File: rtl/pimp_pkg.sv
// Shared PIMP core definitions: fetch sequencer states and the default widths
// used by the fetch sequencer, instruction ROM and control decoder.
package pimp_pkg;

   localparam int unsigned PIMP_PC_W  = 8;
   localparam int unsigned PIMP_OFF_W = 6;
   localparam int unsigned PIMP_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pimp_fetch_seq_if.sv
// Control/fetch bundle between the PIMP control decoder (master) and the
// fetch sequencer (slave).
interface pimp_fetch_seq_if #(
   parameter int unsigned PC_W  = pimp_pkg::PIMP_PC_W,
   parameter int unsigned OFF_W = pimp_pkg::PIMP_OFF_W,
   parameter int unsigned CNT_W = pimp_pkg::PIMP_CNT_W
);

   logic             Start;
   logic [PC_W-1:0]  Start_Addr;
   logic             Branch;
   logic             Zero;
   logic [OFF_W-1:0] Offset;
   logic             Halt;
   logic             Stall;
   logic [PC_W-1:0]  PC;
   logic             Running;
   logic             Done;
   logic             Timeout;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      output Start, Start_Addr, Branch, Zero, Offset, Halt, Stall,
      input  PC, Running, Done, Timeout, InstrCount
   );

   modport slave (
      input  Start, Start_Addr, Branch, Zero, Offset, Halt, Stall,
      output PC, Running, Done, Timeout, InstrCount
   );

endinterface

// File: rtl/pimp_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment and the count sticks at all-ones.
module pimp_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pimp_fetch_seq.sv
// PIMP fetch sequencer: PC, start/halt sequencing, relative branches and the
// retired-instruction counter. Optional RUN watchdog: PIMP_FETCH_WATCHDOG_EN.
module pimp_fetch_seq
   import pimp_pkg::*;
#(
   parameter int unsigned PC_W       = PIMP_PC_W,
   parameter int unsigned OFF_W      = PIMP_OFF_W,
   parameter int unsigned CNT_W      = PIMP_CNT_W,
   parameter int unsigned WDOG_LIMIT = 4096
) (
   input  logic                CLK,
   input  logic                RST_N,
   pimp_fetch_seq_if.slave     bus
);

   fetch_state_t     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             running_q, running_d;
   logic             done_q, done_d;
   logic [PC_W-1:0]  pc_inc_c;
   logic [PC_W-1:0]  pc_br_c;
   logic             halt_now_c;
   logic             wdog_fire_c;
   logic             cnt_clr_c;
   logic             cnt_inc_c;
   logic [CNT_W-1:0] instr_cnt;

   // A zero limit can never be reached by a counter that starts at zero.
   if (WDOG_LIMIT == 0) begin : g_bad_wdog_limit
      $error("pimp_fetch_seq: WDOG_LIMIT must be at least 1");
   end

   // Next-PC candidates; offset is sign-extended and all PC math wraps.
   assign pc_inc_c   = pc_q + PC_W'(1);
   assign pc_br_c    = pc_q + PC_W'($signed(bus.Offset));
   assign halt_now_c = (state_q == RUN) && !bus.Stall && bus.Halt;

`ifdef PIMP_FETCH_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

   logic             wdog_inc_c;
   logic [CNT_W-1:0] wdog_cnt;
   logic             timeout_q, timeout_d;

   // Counts every RUN cycle, stalled or not; fires on the LIMIT-th one.
   assign wdog_inc_c  = (state_q == RUN) && !bus.Start;
   assign wdog_fire_c = wdog_inc_c && (wdog_cnt == WDOG_LAST);

   pimp_sat_counter #(.W(CNT_W)) u_wdog_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (cnt_clr_c),
      .inc   (wdog_inc_c),
      .cnt   (wdog_cnt)
   );

   // Sticky until the next Start; a simultaneous halt suppresses it.
   always_comb begin
      timeout_d = timeout_q;
      if (bus.Start) begin
         timeout_d = 1'b0;
      end else if (wdog_fire_c && !halt_now_c) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign bus.Timeout = timeout_q;
`else
   assign wdog_fire_c = 1'b0;
   assign bus.Timeout = 1'b0;
`endif

   // Start overrides everything; inside RUN, halt beats the watchdog.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_clr_c = 1'b0;
      cnt_inc_c = 1'b0;

      if (bus.Start) begin
         state_d   = LOAD;
         pc_d      = bus.Start_Addr;
         cnt_clr_c = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            LOAD: begin
               state_d   = RUN;
               pc_d      = bus.Start_Addr;
               cnt_clr_c = 1'b1;
            end
            RUN: begin
               if (halt_now_c) begin
                  state_d   = HALTED;
                  cnt_inc_c = 1'b1;
               end else if (wdog_fire_c) begin
                  state_d = HALTED;
               end else if (!bus.Stall) begin
                  cnt_inc_c = 1'b1;
                  pc_d      = (bus.Branch && bus.Zero) ? pc_br_c : pc_inc_c;
               end
            end
            HALTED: begin
               state_d = HALTED;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      running_d = (state_d == RUN);
      done_d    = (state_d == HALTED);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   pimp_sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (cnt_clr_c),
      .inc   (cnt_inc_c),
      .cnt   (instr_cnt)
   );

   assign bus.PC         = pc_q;
   assign bus.Running    = running_q;
   assign bus.Done       = done_q;
   assign bus.InstrCount = instr_cnt;

endmodule
